// File: rtl/secuenciador_salida_dpwm.sv
// Output-stage sequencer: gates pwm_in onto the buck or full-bridge stage with a dead interval
// on enable/changeover, and soft-starts the applied duty command toward the clamped target.
module secuenciador_salida_dpwm #(
    parameter int DEAD_CYCLES      = 200,
    parameter int RAMP_STEP_CYCLES = 100000,
    parameter int DUTY_W           = 4,
    parameter int DUTY_MAX         = 10
) (
    input  logic              CLK_100MHz,
    input  logic              reset,
    input  logic              habilitar,
    input  logic              select_salida,
    input  logic [DUTY_W-1:0] duty_objetivo,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_aplicado,
    output logic              BUCK_Gate,
    output logic              Full_Bridge,
    output logic [1:0]        estado,
    output logic              listo
);

    typedef enum logic [1:0] {
        APAGADO = 2'd0,
        MUERTO  = 2'd1,
        RAMPA   = 2'd2,
        ACTIVO  = 2'd3
    } estado_t;

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int RAMP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [DUTY_W-1:0] DUTY_LIM  = DUTY_W'(DUTY_MAX);

    estado_t           est_q, est_d;
    logic              sel_activa, sel_d;
    logic [DEAD_W-1:0] dead_cnt, dead_d;
    logic [RAMP_W-1:0] paso_cnt, paso_d;
    logic [DUTY_W-1:0] tgt, duty_d, duty_paso;
    logic              cambio, run;

    assign tgt    = (duty_objetivo > DUTY_LIM) ? DUTY_LIM : duty_objetivo;
    assign cambio = (select_salida != sel_activa);
    assign run    = (est_d == RAMPA) || (est_d == ACTIVO);
    assign estado = est_q;

    // Next-state logic; shutdown takes priority over changeover, which takes priority over ramping.
    always_comb begin
        est_d     = est_q;
        sel_d     = sel_activa;
        dead_d    = dead_cnt;
        paso_d    = paso_cnt;
        duty_d    = duty_aplicado;
        duty_paso = duty_aplicado;
        case (est_q)
            APAGADO: begin
                duty_d = '0;
                if (habilitar) begin
                    sel_d  = select_salida;
                    dead_d = '0;
                    est_d  = MUERTO;
                end
            end
            MUERTO: begin
                duty_d = '0;
                if (!habilitar) begin
                    est_d = APAGADO;
                end else if (cambio) begin
                    sel_d  = select_salida;
                    dead_d = '0;
                end else if (dead_cnt == DEAD_LAST) begin
                    paso_d = '0;
                    est_d  = RAMPA;
                end else begin
                    dead_d = dead_cnt + DEAD_W'(1);
                end
            end
            RAMPA: begin
                if (!habilitar) begin
                    duty_d = '0;
                    est_d  = APAGADO;
                end else if (cambio) begin
                    duty_d = '0;
                    sel_d  = select_salida;
                    dead_d = '0;
                    est_d  = MUERTO;
                end else begin
                    if (paso_cnt == RAMP_LAST) begin
                        paso_d    = '0;
                        duty_paso = duty_aplicado + DUTY_W'(1);
                    end else begin
                        paso_d = paso_cnt + RAMP_W'(1);
                    end
                    // Reaching or overshooting the target settles on it; never steps past it.
                    if (tgt <= duty_paso) begin
                        duty_d = tgt;
                        est_d  = ACTIVO;
                    end else begin
                        duty_d = duty_paso;
                    end
                end
            end
            ACTIVO: begin
                if (!habilitar) begin
                    duty_d = '0;
                    est_d  = APAGADO;
                end else if (cambio) begin
                    duty_d = '0;
                    sel_d  = select_salida;
                    dead_d = '0;
                    est_d  = MUERTO;
                end else if (tgt < duty_aplicado) begin
                    duty_d = tgt;
                end else if (tgt > duty_aplicado) begin
                    paso_d = '0;
                    est_d  = RAMPA;
                end
            end
            default: begin
                duty_d = '0;
                est_d  = APAGADO;
            end
        endcase
    end

    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            est_q         <= APAGADO;
            sel_activa    <= 1'b0;
            dead_cnt      <= '0;
            paso_cnt      <= '0;
            duty_aplicado <= '0;
            BUCK_Gate     <= 1'b0;
            Full_Bridge   <= 1'b0;
            listo         <= 1'b0;
        end else begin
            est_q         <= est_d;
            sel_activa    <= sel_d;
            dead_cnt      <= dead_d;
            paso_cnt      <= paso_d;
            duty_aplicado <= duty_d;
            BUCK_Gate     <= pwm_in & run & ~sel_d;
            Full_Bridge   <= pwm_in & run & sel_d;
            listo         <= (est_d == ACTIVO);
        end
    end

endmodule

// File: tb/tb_secuenciador_salida_dpwm.sv
// Scoreboard bench for secuenciador_salida_dpwm: a behavioural model pushes the expected
// registered outputs per driven cycle; they are popped and compared after the clock edge.
module tb_secuenciador_salida_dpwm;

    localparam int DEAD = 4;
    localparam int RSC  = 8;
    localparam int DMAX = 10;

    typedef struct packed {
        logic [1:0] est;
        logic [3:0] duty;
        logic       buck;
        logic       fb;
        logic       listo;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       habilitar = 1'b0;
    logic       select_salida = 1'b0;
    logic [3:0] duty_objetivo = 4'd0;
    logic       pwm_in = 1'b0;
    logic [3:0] duty_aplicado;
    logic       BUCK_Gate, Full_Bridge, listo;
    logic [1:0] estado;

    exp_t q[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   cyc        = 0;
    int   lastBuck   = -1000;
    int   lastFb     = -1000;
    logic prevBuck   = 1'b0;
    logic prevFb     = 1'b0;

    // Behavioural model state
    int   mEst = 0, mDuty = 0, mSel = 0, mDead = 0, mTimer = 0;

    secuenciador_salida_dpwm #(
        .DEAD_CYCLES(DEAD), .RAMP_STEP_CYCLES(RSC), .DUTY_W(4), .DUTY_MAX(DMAX)
    ) dut (
        .CLK_100MHz(clk), .reset(reset), .habilitar(habilitar),
        .select_salida(select_salida), .duty_objetivo(duty_objetivo), .pwm_in(pwm_in),
        .duty_aplicado(duty_aplicado), .BUCK_Gate(BUCK_Gate), .Full_Bridge(Full_Bridge),
        .estado(estado), .listo(listo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv)
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        else
            passCount++;
    endtask

    // Model of one clock edge, using the inputs currently driven.
    function automatic exp_t modelStep();
        exp_t e;
        int tg, nxt, stepped;
        tg = (int'(duty_objetivo) > DMAX) ? DMAX : int'(duty_objetivo);
        nxt = mEst;
        if (reset) begin
            mEst = 0; mDuty = 0; mSel = 0; mDead = 0; mTimer = 0;
            e = '0;
            return e;
        end
        if (mEst != 0 && !habilitar) begin
            nxt = 0; mDuty = 0;
        end else if (mEst == 0) begin
            mDuty = 0;
            if (habilitar) begin mSel = int'(select_salida); mDead = 0; nxt = 1; end
        end else if (int'(select_salida) != mSel) begin
            mSel = int'(select_salida); mDead = 0; mDuty = 0; nxt = 1;
        end else if (mEst == 1) begin
            mDuty = 0;
            if (mDead + 1 == DEAD) begin nxt = 2; mTimer = 0; end
            else mDead++;
        end else if (mEst == 2) begin
            stepped = mDuty;
            mTimer++;
            if (mTimer == RSC) begin mTimer = 0; stepped = mDuty + 1; end
            if (tg <= stepped) begin mDuty = tg; nxt = 3; end
            else mDuty = stepped;
        end else begin
            if (tg < mDuty) mDuty = tg;
            else if (tg > mDuty) begin nxt = 2; mTimer = 0; end
        end
        mEst    = nxt;
        e.est   = 2'(mEst);
        e.duty  = 4'(mDuty);
        e.listo = (mEst == 3);
        e.buck  = pwm_in && (mEst >= 2) && (mSel == 0);
        e.fb    = pwm_in && (mEst >= 2) && (mSel == 1);
        return e;
    endfunction

    task automatic checkCycle();
        exp_t e;
        e = q.pop_front();
        checkOutput("estado", 32'(estado), 32'(e.est));
        checkOutput("duty", 32'(duty_aplicado), 32'(e.duty));
        checkOutput("buck", 32'(BUCK_Gate), 32'(e.buck));
        checkOutput("fb", 32'(Full_Bridge), 32'(e.fb));
        checkOutput("listo", 32'(listo), 32'(e.listo));
        checkOutput("overlap", 32'(BUCK_Gate & Full_Bridge), 32'd0);
        if (Full_Bridge && !prevFb)
            checkOutput("dead_fb", 32'((cyc - lastBuck) > DEAD), 32'd1);
        if (BUCK_Gate && !prevBuck)
            checkOutput("dead_buck", 32'((cyc - lastFb) > DEAD), 32'd1);
        if (BUCK_Gate) lastBuck = cyc;
        if (Full_Bridge) lastFb = cyc;
        prevBuck = BUCK_Gate;
        prevFb   = Full_Bridge;
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic s,
                                 input logic [3:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = r; habilitar = h; select_salida = s; duty_objetivo = t;
            pwm_in = ~pwm_in;
            q.push_back(modelStep());
            @(posedge clk);
            #1;
            cyc++;
            checkCycle();
        end
    endtask

    initial begin
        // Reset with enable held high, then dead time and a ramp to 3 on the buck stage
        applyStimulus(1, 1, 0, 3, 3);
        checkOutput("rst_estado", 32'(estado), 32'd0);
        checkOutput("rst_duty", 32'(duty_aplicado), 32'd0);
        applyStimulus(0, 1, 0, 3, 1);
        checkOutput("s1_muerto", 32'(estado), 32'd1);
        applyStimulus(0, 1, 0, 3, 4);
        checkOutput("s1_rampa", 32'(estado), 32'd2);
        applyStimulus(0, 1, 0, 3, 24);
        checkOutput("s2_activo", 32'(estado), 32'd3);
        checkOutput("s2_listo", 32'(listo), 32'd1);
        checkOutput("s2_duty", 32'(duty_aplicado), 32'd3);

        // Changeover to the full bridge
        applyStimulus(0, 1, 1, 3, 1);
        checkOutput("s3_muerto", 32'(estado), 32'd1);
        checkOutput("s3_duty0", 32'(duty_aplicado), 32'd0);
        applyStimulus(0, 1, 1, 3, 4);
        checkOutput("s3_rampa", 32'(estado), 32'd2);

        // Saturation, decrease, and re-ramp
        applyStimulus(0, 1, 1, 15, 80);
        checkOutput("s4_sat", 32'(duty_aplicado), 32'd10);
        checkOutput("s4_activo", 32'(estado), 32'd3);
        applyStimulus(0, 1, 1, 2, 1);
        checkOutput("s4_drop", 32'(duty_aplicado), 32'd2);
        applyStimulus(0, 1, 1, 5, 17);
        checkOutput("s4_ramp4", 32'(duty_aplicado), 32'd4);
        checkOutput("s4_rampa", 32'(estado), 32'd2);

        // Target below the ramp value, then tgt=0 from enable
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("s5_duty1", 32'(duty_aplicado), 32'd1);
        checkOutput("s5_activo", 32'(estado), 32'd3);
        applyStimulus(0, 0, 1, 0, 2);
        checkOutput("s5_off", 32'(estado), 32'd0);
        applyStimulus(0, 1, 1, 0, 5);
        checkOutput("s5_rampa", 32'(estado), 32'd2);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("s5_zero_act", 32'(estado), 32'd3);

        // Disable mid-ramp, reset mid-dead-time
        applyStimulus(0, 1, 1, 6, 5);
        applyStimulus(0, 0, 1, 6, 1);
        checkOutput("s6_off", 32'(estado), 32'd0);
        checkOutput("s6_fb0", 32'(Full_Bridge), 32'd0);
        applyStimulus(0, 1, 0, 6, 2);
        applyStimulus(1, 1, 0, 6, 1);
        checkOutput("s6_rst", 32'(estado), 32'd0);
        applyStimulus(0, 1, 0, 6, 4);
        checkOutput("s6_dead", 32'(estado), 32'd1);
        applyStimulus(0, 1, 0, 6, 1);
        checkOutput("s6_rampa", 32'(estado), 32'd2);

        // Randomised traffic with occasional toggles of enable/select/target/reset
        for (int i = 0; i < 600; i++) begin
            logic r, h, s;
            logic [3:0] t;
            h = habilitar; s = select_salida; t = duty_objetivo;
            if ($urandom_range(0, 59) == 0) h = ~h;
            if ($urandom_range(0, 49) == 0) s = ~s;
            if ($urandom_range(0, 29) == 0) t = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 299) == 0);
            applyStimulus(r, h, s, t, 1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
